// File: rtl/adc_avg_pkg.sv
// Shared definitions for the per-channel ADC averager.
// Contents:
//   - word addresses of the control/status/overrun/average registers
//   - bit positions inside the CTRL register
//   - acc_width(): accumulator width needed to sum 2**log2_avg samples
package adc_avg_pkg;

   localparam int CTRL_ADDR    = 32'h0000_0000;
   localparam int STATUS_ADDR  = 32'h0000_0001;
   localparam int OVERRUN_ADDR = 32'h0000_0002;
   localparam int AVG_BASE     = 32'h0000_0010;

   localparam int CTRL_ENABLE_BIT = 32'd0;
   localparam int CTRL_CLEAR_BIT  = 32'd1;

   // Summing 2**log2_avg samples of data_w bits never needs more than
   // data_w + log2_avg bits, so the accumulator cannot wrap.
   function automatic int acc_width(input int data_w, input int log2_avg);
      return data_w + log2_avg;
   endfunction

endpackage

// File: rtl/adc_channel_averager_if.sv
// Bundle of the ADC response stream and the Avalon-MM slave port of the
// averager.
// Signals:
//   resp_valid/resp_channel/resp_data    ADC response, single-beat samples
//   s_address/s_read/s_write/
//   s_writedata/s_byteenable             Avalon-MM request side
//   s_waitrequest/s_readdata/
//   s_readdatavalid                      Avalon-MM response side (latency 1)
// Modports:
//   master  drives samples and bus requests (ADC + bus master side)
//   slave   the averager
interface adc_channel_averager_if #(
   parameter int DATA_W = 12,
   parameter int CH_W   = 5,
   parameter int ADDR_W = 10,
   parameter int RD_W   = 16
) ();

   logic                resp_valid;
   logic [CH_W-1:0]     resp_channel;
   logic [DATA_W-1:0]   resp_data;

   logic [ADDR_W-1:0]   s_address;
   logic                s_read;
   logic                s_write;
   logic [RD_W-1:0]     s_writedata;
   logic [RD_W/8-1:0]   s_byteenable;
   logic                s_waitrequest;
   logic [RD_W-1:0]     s_readdata;
   logic                s_readdatavalid;

   modport master (
      output resp_valid, resp_channel, resp_data,
      output s_address, s_read, s_write, s_writedata, s_byteenable,
      input  s_waitrequest, s_readdata, s_readdatavalid
   );

   modport slave (
      input  resp_valid, resp_channel, resp_data,
      input  s_address, s_read, s_write, s_writedata, s_byteenable,
      output s_waitrequest, s_readdata, s_readdatavalid
   );

endinterface

// File: rtl/adc_chan_acc.sv
// One channel of the averager: accumulator, sample counter, latched mean,
// new-data flag and sticky overrun flag.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   sample_en    accepted sample for this channel this cycle
//   data         sample value
//   clr          zero everything (CTRL clear)
//   rd_clr       AVG register of this channel is being read
//   ovr_clr      write-1-to-clear of this channel's overrun bit
//   result       last completed mean
//   new_flag     a mean has completed since the last AVG read
//   ovr          a mean completed while new_flag was still set
module adc_chan_acc
   import adc_avg_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int LOG2_AVG = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_en,
   input  logic [DATA_W-1:0] data,
   input  logic              clr,
   input  logic              rd_clr,
   input  logic              ovr_clr,
   output logic [DATA_W-1:0] result,
   output logic              new_flag,
   output logic              ovr
);

   localparam int ACC_W = acc_width(DATA_W, LOG2_AVG);
   localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

   logic [ACC_W-1:0]  acc_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] result_r;
   logic              new_r;
   logic              ovr_r;

   logic [ACC_W-1:0]  sum_s;
   logic [DATA_W-1:0] mean_s;
   logic              done_s;

   // Running sum including the current sample, and whether it closes a block.
   always_comb begin
      sum_s  = acc_r + ACC_W'(data);
      mean_s = DATA_W'(sum_s >> LOG2_AVG);
      done_s = sample_en && (cnt_r == CNT_LAST);
   end

   // Accumulator and counter; restart after each completed block.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc_r <= '0;
         cnt_r <= '0;
      end else if (done_s) begin
         acc_r <= '0;
         cnt_r <= '0;
      end else if (sample_en) begin
         acc_r <= sum_s;
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Result latch and flags; a completing block beats a same-cycle read or W1C.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         result_r <= '0;
         new_r    <= 1'b0;
         ovr_r    <= 1'b0;
      end else begin
         if (done_s) begin
            result_r <= mean_s;
            new_r    <= 1'b1;
         end else if (rd_clr) begin
            new_r    <= 1'b0;
         end
         if (done_s && new_r) begin
            ovr_r <= 1'b1;
         end else if (ovr_clr) begin
            ovr_r <= 1'b0;
         end
      end
   end

   assign result   = result_r;
   assign new_flag = new_r;
   assign ovr      = ovr_r;

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel decimating averager on the ADC response stream with an
// Avalon-MM slave (read latency 1) exposing results and flags.
// Ports:
//   clk_clk      sole clock
//   reset_reset  synchronous active-high reset
//   bus          slave side of adc_channel_averager_if (ADC stream + Avalon-MM)
// Register map (word addresses):
//   0x00 CTRL     bit0 enable (RW), bit1 clear (W, reads 0)
//   0x01 STATUS   new[] flags
//   0x02 OVERRUN  ovr[] flags, write 1 to clear
//   0x10+c AVG[c] latest mean; reading it clears new[c]
module adc_channel_averager
   import adc_avg_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int CH_W     = 5,
   parameter int NUM_CH   = 8,
   parameter int LOG2_AVG = 4,
   parameter int ADDR_W   = 10,
   parameter int RD_W     = 16
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   adc_channel_averager_if.slave bus
);

   logic              enable_r;
   logic [RD_W-1:0]   readdata_r;
   logic              readdatavalid_r;

   logic              wr_en_s;
   logic              ctrl_wr_s;
   logic              clear_s;
   logic              accept_s;
   logic [NUM_CH-1:0] sample_en_s;
   logic [NUM_CH-1:0] rd_clr_s;
   logic [NUM_CH-1:0] ovr_clr_s;
   logic [NUM_CH-1:0] new_vec_s;
   logic [NUM_CH-1:0] ovr_vec_s;
   logic [DATA_W-1:0] result_s [NUM_CH];
   logic [RD_W-1:0]   avg_s;
   logic [RD_W-1:0]   rdata_s;
   logic              unused_s;

   // Upper write-data/byte-enable bits only matter for wider channel counts.
   assign unused_s = ^{bus.s_writedata, bus.s_byteenable};

   // Bus decode and per-channel strobes; a write alongside a read is dropped,
   // and a clear discards any sample in the same cycle.
   always_comb begin
      wr_en_s     = bus.s_write && !bus.s_read;
      ctrl_wr_s   = wr_en_s && (bus.s_address == ADDR_W'(CTRL_ADDR)) && bus.s_byteenable[0];
      clear_s     = ctrl_wr_s && bus.s_writedata[CTRL_CLEAR_BIT];
      accept_s    = bus.resp_valid && enable_r && (int'(bus.resp_channel) < NUM_CH) && !clear_s;
      sample_en_s = '0;
      rd_clr_s    = '0;
      ovr_clr_s   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sample_en_s[c] = accept_s && (bus.resp_channel == CH_W'(c));
         rd_clr_s[c]    = bus.s_read && (bus.s_address == ADDR_W'(AVG_BASE + c));
         ovr_clr_s[c]   = wr_en_s && (bus.s_address == ADDR_W'(OVERRUN_ADDR)) &&
                          bus.s_byteenable[c / 8] && bus.s_writedata[c];
      end
   end

   // Channel datapaths.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      adc_chan_acc #(
         .DATA_W   (DATA_W),
         .LOG2_AVG (LOG2_AVG)
      ) u_acc (
         .clk       (clk_clk),
         .rst       (reset_reset),
         .sample_en (sample_en_s[g]),
         .data      (bus.resp_data),
         .clr       (clear_s),
         .rd_clr    (rd_clr_s[g]),
         .ovr_clr   (ovr_clr_s[g]),
         .result    (result_s[g]),
         .new_flag  (new_vec_s[g]),
         .ovr       (ovr_vec_s[g])
      );
   end

   // Read mux; unmapped addresses return zero.
   always_comb begin
      avg_s = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         avg_s = avg_s | ((bus.s_address == ADDR_W'(AVG_BASE + c)) ? RD_W'(result_s[c]) : '0);
      end
      rdata_s = '0;
      case (bus.s_address)
         ADDR_W'(CTRL_ADDR):    rdata_s = RD_W'(enable_r);
         ADDR_W'(STATUS_ADDR):  rdata_s = RD_W'(new_vec_s);
         ADDR_W'(OVERRUN_ADDR): rdata_s = RD_W'(ovr_vec_s);
         default:               rdata_s = avg_s;
      endcase
   end

   // Enable bit keeps its last written value across a clear.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         enable_r <= 1'b1;
      end else if (ctrl_wr_s) begin
         enable_r <= bus.s_writedata[CTRL_ENABLE_BIT];
      end
   end

   // Read pipeline stage; reset kills any read still in flight.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         readdata_r      <= '0;
         readdatavalid_r <= 1'b0;
      end else begin
         readdatavalid_r <= bus.s_read;
         if (bus.s_read) begin
            readdata_r <= rdata_s;
         end
      end
   end

   assign bus.s_waitrequest   = 1'b0;
   assign bus.s_readdata      = readdata_r;
   assign bus.s_readdatavalid = readdatavalid_r;

endmodule
